// File: rtl/histo_uart_rx_pkg.sv
// Shared types and widths for the histogram UART receiver.
package histo_uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  localparam int BYTES_PER_BIN = 3;
  localparam int WORD_W        = 24;
  localparam int SUM_W         = 34;
  localparam int IDX_W         = 10;

endpackage

// File: rtl/histo_uart_rx_byte.sv
// 8N1 byte receiver: input synchronizer, start/data/stop sampling and stop-bit check.
module uart_rx_byte
  import histo_uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       framing_err,
  output logic       rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_q;
  logic             prev_q;
  logic             rx_line;
  logic             fall;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], uart};
      prev_q <= sync_q[1];
    end
  end

  assign rx_line = sync_q[1];
  assign fall    = prev_q & ~rx_line;

  // Every sample point is counted from the start-bit centre found in START.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_line ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_line, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          state_d = IDLE;
          if (rx_line) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign framing_err = ferr_q;
  assign rx_busy     = (state_q != IDLE);

endmodule

// File: rtl/histo_uart_rx.sv
// Histogram stream receiver: 3-byte bins, bin numbering, frame sum and idle timeout.
module histo_uart_rx
  import histo_uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int NUM_BINS     = 1024,
  parameter int TIMEOUT_CLKS = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart,
  output logic [WORD_W-1:0] bin_data,
  output logic [IDX_W-1:0]  bin_index,
  output logic              bin_valid,
  output logic              frame_done,
  output logic [SUM_W-1:0]  frame_sum,
  output logic              framing_err,
  output logic              timeout_err,
  output logic              busy
);

  localparam int IDLE_W = $clog2(TIMEOUT_CLKS);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CLKS - 1);
  localparam logic [IDX_W-1:0]  LAST_BIN  = IDX_W'(NUM_BINS - 1);
  localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_BIN - 1);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ferr;
  logic              rx_busy;

  logic [1:0]        byte_cnt_q, byte_cnt_d, cnt_base;
  logic [15:0]       word_q, word_d;
  logic [IDX_W-1:0]  bin_cnt_q, bin_cnt_d, idx_base;
  logic [SUM_W-1:0]  sum_q, sum_d, sum_base, new_sum;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [WORD_W-1:0] bin_data_q, bin_data_d;
  logic [IDX_W-1:0]  bin_index_q, bin_index_d;
  logic              bin_valid_q, bin_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [SUM_W-1:0]  frame_sum_q, frame_sum_d;
  logic              timeout_err_q, timeout_err_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .uart       (uart),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .framing_err(rx_ferr),
    .rx_busy    (rx_busy)
  );

  // A timeout clears state first so a byte landing in the same cycle starts a fresh word.
  always_comb begin
    byte_cnt_d    = byte_cnt_q;
    word_d        = word_q;
    bin_cnt_d     = bin_cnt_q;
    sum_d         = sum_q;
    bin_data_d    = bin_data_q;
    bin_index_d   = bin_index_q;
    bin_valid_d   = 1'b0;
    frame_done_d  = 1'b0;
    frame_sum_d   = frame_sum_q;
    timeout_err_d = 1'b0;
    cnt_base      = byte_cnt_q;
    idx_base      = bin_cnt_q;
    sum_base      = sum_q;
    new_sum       = '0;
    idle_d        = idle_q + 1'b1;

    if (idle_q == IDLE_LAST) begin
      idle_d = '0;
      if (byte_cnt_q != '0 || bin_cnt_q != '0) begin
        timeout_err_d = 1'b1;
        cnt_base      = '0;
        idx_base      = '0;
        sum_base      = '0;
        bin_index_d   = '0;
      end
    end

    byte_cnt_d = cnt_base;
    bin_cnt_d  = idx_base;
    sum_d      = sum_base;

    if (rx_ferr) byte_cnt_d = '0;

    if (rx_valid) begin
      idle_d = '0;
      word_d = {word_q[7:0], rx_data};
      if (cnt_base == LAST_BYTE) begin
        byte_cnt_d  = '0;
        bin_valid_d = 1'b1;
        bin_data_d  = {word_q, rx_data};
        bin_index_d = idx_base;
        new_sum     = sum_base + SUM_W'({word_q, rx_data});
        if (idx_base == LAST_BIN) begin
          frame_done_d = 1'b1;
          frame_sum_d  = new_sum;
          sum_d        = '0;
          bin_cnt_d    = '0;
        end else begin
          sum_d     = new_sum;
          bin_cnt_d = idx_base + 1'b1;
        end
      end else begin
        byte_cnt_d = cnt_base + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt_q    <= '0;
      word_q        <= '0;
      bin_cnt_q     <= '0;
      sum_q         <= '0;
      idle_q        <= '0;
      bin_data_q    <= '0;
      bin_index_q   <= '0;
      bin_valid_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_sum_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      byte_cnt_q    <= byte_cnt_d;
      word_q        <= word_d;
      bin_cnt_q     <= bin_cnt_d;
      sum_q         <= sum_d;
      idle_q        <= idle_d;
      bin_data_q    <= bin_data_d;
      bin_index_q   <= bin_index_d;
      bin_valid_q   <= bin_valid_d;
      frame_done_q  <= frame_done_d;
      frame_sum_q   <= frame_sum_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bin_data    = bin_data_q;
  assign bin_index   = bin_index_q;
  assign bin_valid   = bin_valid_q;
  assign frame_done  = frame_done_q;
  assign frame_sum   = frame_sum_q;
  assign framing_err = rx_ferr;
  assign timeout_err = timeout_err_q;
  assign busy        = rx_busy | (byte_cnt_q != '0) | (bin_cnt_q != '0);

endmodule

// File: tb/tb_histo_uart_rx.sv
// Directed bench for histo_uart_rx using a small frame and short timeout.
module tb_histo_uart_rx;

  localparam int CPB  = 8;
  localparam int NB   = 16;
  localparam int TO   = 400;
  localparam int GAP  = 16;
  localparam int LAT  = 3 + CPB / 2 + 9 * CPB + 1;

  logic        clk;
  logic        reset_n;
  logic        uart;
  logic [23:0] bin_data;
  logic [9:0]  bin_index;
  logic        bin_valid;
  logic        frame_done;
  logic [33:0] frame_sum;
  logic        framing_err;
  logic        timeout_err;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int start_cyc;

  int          n_valid = 0, n_fd = 0, n_fe = 0, n_to = 0, n_dbl = 0, valid_cyc = 0;
  logic [23:0] last_data = '0;
  logic [9:0]  last_idx = '0;
  logic        last_fd = 1'b0;
  logic        prev_bv = 1'b0, prev_fd = 1'b0, prev_fe = 1'b0, prev_to = 1'b0;

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [23:0] exp_data;
    logic [9:0]  exp_idx;
  } vec_t;

  vec_t vecs[5];

  histo_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .NUM_BINS    (NB),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset_n),
    .uart       (uart),
    .bin_data   (bin_data),
    .bin_index  (bin_index),
    .bin_valid  (bin_valid),
    .frame_done (frame_done),
    .frame_sum  (frame_sum),
    .framing_err(framing_err),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters and last-bin capture, sampled between active edges.
  always @(negedge clk) begin
    if (bin_valid) begin
      n_valid   <= n_valid + 1;
      last_data <= bin_data;
      last_idx  <= bin_index;
      last_fd   <= frame_done;
      valid_cyc <= cyc;
    end
    if (frame_done)  n_fd <= n_fd + 1;
    if (framing_err) n_fe <= n_fe + 1;
    if (timeout_err) n_to <= n_to + 1;
    if ((bin_valid && prev_bv) || (frame_done && prev_fd) ||
        (framing_err && prev_fe) || (timeout_err && prev_to))
      n_dbl <= n_dbl + 1;
    prev_bv <= bin_valid;
    prev_fd <= frame_done;
    prev_fe <= framing_err;
    prev_to <= timeout_err;
  end

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk);
    #2;
    uart = 1'b0;
    start_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #2;
      uart = b[i];
    end
    repeat (CPB) @(posedge clk);
    #2;
    uart = stop_bit;
    repeat (CPB) @(posedge clk);
    #2;
    uart = 1'b1;
    repeat (GAP) @(posedge clk);
  endtask

  task automatic apply_stimulus(input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
  endtask

  initial begin
    int nv0, fe0, to0, fd0;

    vecs[0] = '{8'h01, 8'h02, 8'h03, 24'h010203, 10'd0};
    vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF, 10'd1};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 24'h000000, 10'd2};
    vecs[3] = '{8'hA5, 8'h5A, 8'h3C, 24'hA55A3C, 10'd3};
    vecs[4] = '{8'h80, 8'h00, 8'h01, 24'h800001, 10'd4};

    uart    = 1'b1;
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_bin_valid", 64'(bin_valid), 64'd0);
    check_output("rst_frame_done", 64'(frame_done), 64'd0);
    check_output("rst_bin_data", 64'(bin_data), 64'd0);
    check_output("rst_bin_index", 64'(bin_index), 64'd0);
    check_output("rst_frame_sum", 64'(frame_sum), 64'd0);
    check_output("rst_framing_err", 64'(framing_err), 64'd0);
    check_output("rst_timeout_err", 64'(timeout_err), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);

    for (int i = 0; i < 5; i++) begin
      nv0 = n_valid;
      apply_stimulus(vecs[i].b0, vecs[i].b1, vecs[i].b2);
      check_output($sformatf("vec%0d_count", i), 64'(n_valid - nv0), 64'd1);
      check_output($sformatf("vec%0d_data", i), 64'(last_data), 64'(vecs[i].exp_data));
      check_output($sformatf("vec%0d_index", i), 64'(last_idx), 64'(vecs[i].exp_idx));
      check_output($sformatf("vec%0d_fd", i), 64'(last_fd), 64'd0);
      if (i == 0) check_output("first_latency", 64'(valid_cyc - start_cyc), 64'(LAT));
    end

    nv0 = n_valid;
    fe0 = n_fe;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    check_output("ferr_pulse", 64'(n_fe - fe0), 64'd1);
    check_output("ferr_no_valid", 64'(n_valid - nv0), 64'd0);
    apply_stimulus(8'h33, 8'h44, 8'h55);
    check_output("ferr_next_count", 64'(n_valid - nv0), 64'd1);
    check_output("ferr_next_data", 64'(last_data), 64'h334455);
    check_output("ferr_next_index", 64'(last_idx), 64'd5);

    to0 = n_to;
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (TO + 50) @(posedge clk);
    #1;
    check_output("to_idx6_pulse", 64'(n_to - to0), 64'd1);
    check_output("to_idx6_index", 64'(bin_index), 64'd0);
    check_output("to_idx6_busy", 64'(busy), 64'd0);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    repeat (TO + 50) @(posedge clk);
    #1;
    check_output("to_idx0_pulse", 64'(n_to - to0), 64'd2);
    check_output("to_idx0_busy", 64'(busy), 64'd0);
    repeat (TO + 50) @(posedge clk);
    #1;
    check_output("to_quiet_no_pulse", 64'(n_to - to0), 64'd2);

    nv0 = n_valid;
    fe0 = n_fe;
    to0 = n_to;
    @(posedge clk);
    #2 uart = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    #2 uart = 1'b1;
    repeat (CPB * 2) @(posedge clk);
    #1;
    check_output("glitch_no_byte", 64'(n_valid - nv0), 64'd0);
    check_output("glitch_no_ferr", 64'(n_fe - fe0), 64'd0);
    check_output("glitch_no_to", 64'(n_to - to0), 64'd0);
    check_output("glitch_busy", 64'(busy), 64'd0);

    fd0 = n_fd;
    for (int i = 0; i < NB; i++) begin
      apply_stimulus(8'h00, 8'h00, 8'(i));
      check_output($sformatf("frame_bin%0d_index", i), 64'(last_idx), 64'(i));
      check_output($sformatf("frame_bin%0d_data", i), 64'(last_data), 64'(i));
    end
    check_output("frame_done_count", 64'(n_fd - fd0), 64'd1);
    check_output("frame_done_with_last", 64'(last_fd), 64'd1);
    check_output("frame_sum", 64'(frame_sum), 64'd120);
    apply_stimulus(8'h00, 8'h00, 8'h07);
    check_output("wrap_index", 64'(last_idx), 64'd0);
    check_output("wrap_no_fd", 64'(n_fd - fd0), 64'd1);
    check_output("wrap_sum_hold", 64'(frame_sum), 64'd120);

    apply_stimulus(8'h00, 8'h00, 8'h08);
    apply_stimulus(8'h00, 8'h00, 8'h09);
    check_output("pre_reset_index", 64'(last_idx), 64'd2);
    @(posedge clk);
    #2 uart = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_output("midrst_bin_valid", 64'(bin_valid), 64'd0);
    check_output("midrst_bin_index", 64'(bin_index), 64'd0);
    check_output("midrst_bin_data", 64'(bin_data), 64'd0);
    check_output("midrst_frame_sum", 64'(frame_sum), 64'd0);
    check_output("midrst_busy", 64'(busy), 64'd0);
    uart = 1'b1;
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (CPB * 2) @(posedge clk);
    nv0 = n_valid;
    apply_stimulus(8'hDE, 8'hAD, 8'hBE);
    check_output("postrst_count", 64'(n_valid - nv0), 64'd1);
    check_output("postrst_index", 64'(last_idx), 64'd0);
    check_output("postrst_data", 64'(last_data), 64'hDEADBE);

    check_output("single_cycle_pulses", 64'(n_dbl), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
